// File: rtl/debug_pkg.sv
// Shared command/ack codes and controller state encoding for the
// host-facing debug controller.
package debug_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_HALT = 8'h03;
    localparam logic [7:0] CMD_DUMP = 8'h04;

    localparam logic [7:0] ACK_STEP = 8'h02;
    localparam logic [7:0] ACK_HALT = 8'h03;
    localparam logic [7:0] ACK_DONE = 8'hDD;

    localparam logic [2:0] ACK_LEN  = 3'd1;
    localparam logic [2:0] WORD_LEN = 3'd4;

    typedef enum logic [2:0] {
        ST_HALTED,
        ST_RUN,
        ST_STEP,
        ST_ACK,
        ST_DUMP_ADDR,
        ST_DUMP_LATCH,
        ST_DUMP_SEND
    } state_e;

    // Acks reuse the word serializer: the code sits in the MSB lane.
    function automatic logic [31:0] ack_word(input logic [7:0] code);
        return {code, 24'h00_0000};
    endfunction

endpackage

// File: rtl/tx_word_serializer.sv
// Loads up to 4 bytes of a 32-bit word and emits them MSB first over a
// valid/ready byte channel; done flags the final handshake.
module tx_word_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [2:0]  load_len,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        done
);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  remaining_q, remaining_d;
    logic        valid_q, valid_d;
    logic        fire;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        shift_d     = shift_q;
        remaining_d = remaining_q;
        valid_d     = valid_q;
        fire        = valid_q & tx_ready;
        done        = fire && (remaining_q == 3'd1);
        if (load) begin
            shift_d     = load_word;
            remaining_d = load_len;
            valid_d     = 1'b1;
        end else if (fire) begin
            shift_d     = {shift_q[23:0], 8'h00};
            remaining_d = remaining_q - 3'd1;
            valid_d     = (remaining_q != 3'd1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
        end
    end

    assign tx_data  = shift_q[31:24];
    assign tx_valid = valid_q;

endmodule

// File: rtl/debug_unit_ctrl.sv
// Debug controller: decodes UART command bytes, gates pipeline advance and
// streams the GPRs (and optionally the PC) back to the host while halted.
module debug_unit_ctrl
    import debug_pkg::*;
#(
    parameter bit          DUMP_PC = 1'b1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             pipe_enable,
    output logic             debug_on,
    output logic [4:0]       debug_read_reg,
    input  logic [31:0]      debug_reg_data,
    input  logic [31:0]      pc_value,
    input  logic             prog_done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [5:0] LAST_INDEX = DUMP_PC ? 6'd32 : 6'd31;

    state_e           state_q, state_d;
    logic [5:0]       index_q, index_d;
    logic             pipe_enable_q, pipe_enable_d;
    logic             debug_on_q, debug_on_d;
    logic [4:0]       debug_read_reg_q, debug_read_reg_d;
    logic             rx_ready_q, rx_ready_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    logic             ser_load;
    logic [31:0]      ser_word;
    logic [2:0]       ser_len;
    logic             ser_done;
    logic             rx_fire;
    logic             end_of_prog;

    assign rx_fire     = rx_valid & rx_ready_q;
    assign end_of_prog = prog_done & pipe_enable_q;

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        ser_load = 1'b0;
        ser_word = '0;
        ser_len  = '0;
        unique case (state_q)
            ST_HALTED: begin
                if (rx_fire) begin
                    unique case (rx_data)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_HALT: begin
                            state_d  = ST_ACK;
                            ser_load = 1'b1;
                            ser_word = ack_word(ACK_HALT);
                            ser_len  = ACK_LEN;
                        end
                        CMD_DUMP: begin
                            state_d = ST_DUMP_ADDR;
                            index_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // End of program outranks a HALT arriving on the same edge.
                if (end_of_prog) begin
                    state_d  = ST_ACK;
                    ser_load = 1'b1;
                    ser_word = ack_word(ACK_DONE);
                    ser_len  = ACK_LEN;
                end else if (rx_fire && rx_data == CMD_HALT) begin
                    state_d  = ST_ACK;
                    ser_load = 1'b1;
                    ser_word = ack_word(ACK_HALT);
                    ser_len  = ACK_LEN;
                end
            end
            ST_STEP: begin
                state_d  = ST_ACK;
                ser_load = 1'b1;
                ser_word = ack_word(end_of_prog ? ACK_DONE : ACK_STEP);
                ser_len  = ACK_LEN;
            end
            ST_ACK: begin
                if (ser_done) state_d = ST_HALTED;
            end
            ST_DUMP_ADDR: state_d = ST_DUMP_LATCH;
            ST_DUMP_LATCH: begin
                // RF read data is valid here, one cycle after the address moved.
                state_d  = ST_DUMP_SEND;
                ser_load = 1'b1;
                ser_word = (index_q == 6'd32) ? pc_value : debug_reg_data;
                ser_len  = WORD_LEN;
            end
            ST_DUMP_SEND: begin
                if (ser_done) begin
                    if (index_q == LAST_INDEX) begin
                        state_d = ST_HALTED;
                        index_d = '0;
                    end else begin
                        state_d = ST_DUMP_ADDR;
                        index_d = index_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        pipe_enable_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
        rx_ready_d       = (state_d == ST_HALTED) || (state_d == ST_RUN);
        debug_on_d       = (state_d == ST_DUMP_ADDR) || (state_d == ST_DUMP_LATCH) ||
                           (state_d == ST_DUMP_SEND);
        debug_read_reg_d = index_d[4:0];
        cycle_count_d    = cycle_count_q;
        if (pipe_enable_q && (cycle_count_q != '1)) cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_HALTED;
            index_q          <= '0;
            pipe_enable_q    <= 1'b0;
            debug_on_q       <= 1'b0;
            debug_read_reg_q <= '0;
            rx_ready_q       <= 1'b1;
            cycle_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            index_q          <= index_d;
            pipe_enable_q    <= pipe_enable_d;
            debug_on_q       <= debug_on_d;
            debug_read_reg_q <= debug_read_reg_d;
            rx_ready_q       <= rx_ready_d;
            cycle_count_q    <= cycle_count_d;
        end
    end

    tx_word_serializer u_tx_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_word (ser_word),
        .load_len  (ser_len),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .done      (ser_done)
    );

    assign pipe_enable    = pipe_enable_q;
    assign debug_on       = debug_on_q;
    assign debug_read_reg = debug_read_reg_q;
    assign rx_ready       = rx_ready_q;
    assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Self-checking bench for debug_unit_ctrl: command table, directed
// multi-cycle sequences and a randomized run against a transaction model.
module tb_debug_unit_ctrl;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        pipe_enable;
    logic        debug_on;
    logic [4:0]  debug_read_reg;
    logic [31:0] debug_reg_data;
    logic [31:0] pc_value;
    logic        prog_done;
    logic [31:0] cycle_count;

    debug_unit_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .pipe_enable    (pipe_enable),
        .debug_on       (debug_on),
        .debug_read_reg (debug_read_reg),
        .debug_reg_data (debug_reg_data),
        .pc_value       (pc_value),
        .prog_done      (prog_done),
        .cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    // Register file model: one-cycle read latency on the debug port.
    logic [31:0] rf [32];
    always @(posedge clk) debug_reg_data <= rf[debug_read_reg];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b0;
        prog_done = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pipe_enable"}, pipe_enable, 0);
        check({tag, "_debug_on"}, debug_on, 0);
        check({tag, "_read_reg"}, debug_read_reg, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_rx_ready"}, rx_ready, 1);
        check({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // Present one byte for one edge; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] dump_byte(input int n);
        logic [31:0] w;
        w = (n / 4 < 32) ? rf[n / 4] : pc_value;
        return w[31 - 8 * (n % 4) -: 8];
    endfunction

    // ---------------- transaction-level reference model ----------------
    typedef enum {M_HALTED, M_RUNNING, M_STEPPING, M_RESPONDING} mode_e;
    mode_e       mode;
    logic [7:0]  exp_q[$];
    bit          resp_is_dump;
    logic [31:0] exp_count;

    task automatic rand_cycle(input bit allow_cmds);
        mode_e      nm;
        logic [7:0] cmd;
        int         r;
        bit         en;

        check("rand_pipe_enable", pipe_enable, (mode == M_RUNNING) || (mode == M_STEPPING));
        check("rand_rx_ready", rx_ready, (mode == M_HALTED) || (mode == M_RUNNING));
        check("rand_debug_on", debug_on, (mode == M_RESPONDING) && resp_is_dump);
        check("rand_cycle_count", cycle_count, exp_count);
        if (mode != M_RESPONDING) check("rand_tx_idle", tx_valid, 0);
        else if (!resp_is_dump) check("rand_ack_valid", tx_valid, 1);

        r   = $urandom_range(0, 39);
        cmd = (r < 10) ? CMD_RUN : (r < 20) ? CMD_STEP : (r < 30) ? CMD_HALT :
              (r < 32) ? CMD_DUMP : 8'($urandom_range(5, 255));
        rx_data   = cmd;
        rx_valid  = allow_cmds && ($urandom_range(0, 2) == 0);
        tx_ready  = !allow_cmds || ($urandom_range(0, 3) != 0);
        prog_done = allow_cmds && ($urandom_range(0, 15) == 0);

        nm = mode;
        if (tx_valid && tx_ready && mode == M_RESPONDING) begin
            if (exp_q.size() == 0) begin
                check("rand_extra_byte", 1, 0);
            end else begin
                check("rand_tx_byte", tx_data, exp_q.pop_front());
                if (exp_q.size() == 0) nm = M_HALTED;
            end
        end
        en = (mode == M_RUNNING) || (mode == M_STEPPING);
        if (en && exp_count != 32'hFFFF_FFFF) exp_count++;
        case (mode)
            M_HALTED: if (rx_valid) begin
                if (cmd == CMD_RUN) nm = M_RUNNING;
                else if (cmd == CMD_STEP) nm = M_STEPPING;
                else if (cmd == CMD_HALT) begin
                    exp_q.push_back(ACK_HALT);
                    resp_is_dump = 1'b0;
                    nm = M_RESPONDING;
                end else if (cmd == CMD_DUMP) begin
                    for (int n = 0; n < 132; n++) exp_q.push_back(dump_byte(n));
                    resp_is_dump = 1'b1;
                    nm = M_RESPONDING;
                end
            end
            M_RUNNING: begin
                if (prog_done) begin
                    exp_q.push_back(ACK_DONE);
                    resp_is_dump = 1'b0;
                    nm = M_RESPONDING;
                end else if (rx_valid && cmd == CMD_HALT) begin
                    exp_q.push_back(ACK_HALT);
                    resp_is_dump = 1'b0;
                    nm = M_RESPONDING;
                end
            end
            M_STEPPING: begin
                exp_q.push_back(prog_done ? ACK_DONE : ACK_STEP);
                resp_is_dump = 1'b0;
                nm = M_RESPONDING;
            end
            default: ;
        endcase
        mode = nm;
        tick();
    endtask

    typedef struct packed {
        logic [7:0] cmd;
        logic       exp_pe;
        logic       exp_txv;
        logic [7:0] exp_txd;
        logic       exp_dbg;
        logic       exp_rxr;
    } vec_t;

    vec_t        vecs[7];
    logic [7:0]  got[$];
    int          nbytes;
    int          dbg_low;

    initial begin
        vecs[0] = '{8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{8'h02, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[3] = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        pc_value = 32'h0000_0040;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;

        // Single command from HALTED: outputs in the first cycle after acceptance.
        foreach (vecs[i]) begin
            do_reset();
            send_cmd(vecs[i].cmd);
            check($sformatf("vec%0d_pipe_enable", i), pipe_enable, vecs[i].exp_pe);
            check($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].exp_txv);
            check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].exp_txd);
            check($sformatf("vec%0d_debug_on", i), debug_on, vecs[i].exp_dbg);
            check($sformatf("vec%0d_rx_ready", i), rx_ready, vecs[i].exp_rxr);
        end

        // STEP: exactly one enabled cycle, then ack 0x02 held until ready.
        do_reset();
        send_cmd(CMD_STEP);
        check("step_pe_on", pipe_enable, 1);
        tick();
        check("step_pe_off", pipe_enable, 0);
        check("step_ack_valid", tx_valid, 1);
        check("step_ack_data", tx_data, ACK_STEP);
        check("step_count", cycle_count, 1);
        tick();
        check("step_ack_hold_valid", tx_valid, 1);
        check("step_ack_hold_data", tx_data, ACK_STEP);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("step_ack_gone", tx_valid, 0);
        check("step_rx_ready", rx_ready, 1);
        check("step_pe_idle", pipe_enable, 0);

        // RUN for 10 enabled cycles, then HALT.
        do_reset();
        send_cmd(CMD_RUN);
        repeat (9) tick();
        check("run_pe", pipe_enable, 1);
        send_cmd(CMD_HALT);
        check("halt_pe_drop", pipe_enable, 0);
        check("halt_ack_valid", tx_valid, 1);
        check("halt_ack_data", tx_data, ACK_HALT);
        check("halt_count", cycle_count, 10);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("halt_done_rx_ready", rx_ready, 1);

        // prog_done and HALT on the same edge: single 0xDD ack.
        do_reset();
        send_cmd(CMD_RUN);
        repeat (3) tick();
        prog_done = 1'b1;
        send_cmd(CMD_HALT);
        prog_done = 1'b0;
        check("done_pe", pipe_enable, 0);
        check("done_ack_valid", tx_valid, 1);
        check("done_ack_data", tx_data, ACK_DONE);
        check("done_count", cycle_count, 4);
        tx_ready = 1'b1;
        tick();
        check("done_no_second_ack", tx_valid, 0);
        tick();
        tx_ready = 1'b0;
        check("done_still_idle", tx_valid, 0);
        check("done_halted_rx_ready", rx_ready, 1);
        check("done_halted_pe", pipe_enable, 0);

        // Full dump with tx_ready toggling.
        do_reset();
        send_cmd(CMD_DUMP);
        check("dump_debug_on_rise", debug_on, 1);
        got.delete();
        nbytes  = 0;
        dbg_low = 0;
        for (int c = 0; c < 3000 && nbytes < 132; c++) begin
            tx_ready = c[0];
            if (!debug_on) dbg_low++;
            check("dump_pe_low", pipe_enable, 0);
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                nbytes++;
            end
            tick();
        end
        tx_ready = 1'b1;
        check("dump_byte_count", nbytes, 132);
        check("dump_debug_on_held", dbg_low, 0);
        check("dump_debug_on_fall", debug_on, 0);
        check("dump_tx_idle", tx_valid, 0);
        check("dump_rx_ready", rx_ready, 1);
        for (int n = 0; n < got.size(); n++)
            check($sformatf("dump_byte%0d", n), got[n], dump_byte(n));
        tick();
        check("dump_no_trailing_byte", tx_valid, 0);
        tx_ready = 1'b0;

        // DUMP while running and junk while halted are both ignored.
        do_reset();
        send_cmd(CMD_RUN);
        send_cmd(CMD_DUMP);
        check("run_dump_pe", pipe_enable, 1);
        check("run_dump_debug_on", debug_on, 0);
        check("run_dump_tx", tx_valid, 0);
        check("run_dump_rx_ready", rx_ready, 1);
        send_cmd(CMD_HALT);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        send_cmd(8'h7F);
        tick();
        check("junk_pe", pipe_enable, 0);
        check("junk_tx", tx_valid, 0);
        check("junk_debug_on", debug_on, 0);
        check("junk_rx_ready", rx_ready, 1);

        // Reset after 50 dump bytes.
        do_reset();
        send_cmd(CMD_DUMP);
        tx_ready = 1'b1;
        nbytes   = 0;
        for (int c = 0; c < 1000 && nbytes < 50; c++) begin
            if (tx_valid) nbytes++;
            tick();
        end
        check("mid_dump_bytes", nbytes, 50);
        rst = 1'b1;
        tick();
        check_reset_values("mid_dump_reset");
        rst = 1'b0;
        tick();
        check("mid_dump_after_tx", tx_valid, 0);
        check("mid_dump_after_dbg", debug_on, 0);

        // Randomized run against the transaction model.
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        pc_value = $urandom;
        do_reset();
        mode         = M_HALTED;
        exp_q.delete();
        resp_is_dump = 1'b0;
        exp_count    = 0;
        for (int c = 0; c < 4000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 2000 && (mode == M_RESPONDING || mode == M_STEPPING); c++)
            rand_cycle(1'b0);
        check("rand_drained", (mode == M_RESPONDING) || (mode == M_STEPPING), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
